// File: rtl/rename_regfile.sv
// Architectural register file with per-register rename tags (r0 hardwired to zero).
// Define RENAME_BYPASS_EN to forward a tag-matching commit to the read ports in the same cycle.
module rename_regfile #(
    parameter int unsigned RSID_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_read_en_1,
    input  logic [4:0]            i_read_addr_1,
    output logic                  o_read_is_rsid_1,
    output logic [31:0]           o_read_data_1,
    input  logic                  i_read_en_2,
    input  logic [4:0]            i_read_addr_2,
    output logic                  o_read_is_rsid_2,
    output logic [31:0]           o_read_data_2,
    input  logic                  i_rename_en,
    input  logic [4:0]            i_rename_addr,
    input  logic [RSID_WIDTH-1:0] i_rename_rsid,
    input  logic                  i_commit_en,
    input  logic [4:0]            i_commit_addr,
    input  logic [RSID_WIDTH-1:0] i_commit_rsid,
    input  logic [31:0]           i_commit_data,
    input  logic                  i_flush,
    output logic [4:0]            o_busy_count
);

    logic [31:0]           r_data [1:31];
    logic [RSID_WIDTH-1:0] r_tag  [1:31];
    logic [31:1]           r_busy;
    logic [4:0]            r_busy_count;

    logic [31:0]           w_data_d [1:31];
    logic [RSID_WIDTH-1:0] w_tag_d  [1:31];
    logic [31:1]           w_busy_d;
    logic [4:0]            w_busy_count_d;

    logic [31:1]           w_ren_hit;
    logic [31:1]           w_com_hit;
    logic [31:1]           w_com_clr;
    logic                  w_inc;
    logic                  w_dec;
    logic [32:0]           w_rd_1;
    logic [32:0]           w_rd_2;

    // Returns {is_rsid, data} for one read port from registered state.
    function automatic logic [32:0] f_read(input logic en, input logic [4:0] addr);
        logic [32:0] result;
        result = '0;
        if (en) begin
            for (int i = 1; i < 32; i++) begin
                if (addr == 5'(i)) begin
                    if (r_busy[i]) begin
                        result = {1'b1, 32'(r_tag[i])};
`ifdef RENAME_BYPASS_EN
                        if (i_commit_en && (i_commit_addr == addr) &&
                            (r_tag[i] == i_commit_rsid)) begin
                            result = {1'b0, i_commit_data};
                        end
`endif
                    end else begin
                        result = {1'b0, r_data[i]};
                    end
                end
            end
        end
        return result;
    endfunction

    always_comb begin
        w_rd_1 = '0;
        w_rd_2 = '0;
        // Outputs are forced quiet while reset is held, bypass included.
        if (i_rst_n) begin
            w_rd_1 = f_read(i_read_en_1, i_read_addr_1);
            w_rd_2 = f_read(i_read_en_2, i_read_addr_2);
        end
    end

    assign o_read_is_rsid_1 = w_rd_1[32];
    assign o_read_data_1    = w_rd_1[31:0];
    assign o_read_is_rsid_2 = w_rd_2[32];
    assign o_read_data_2    = w_rd_2[31:0];
    assign o_busy_count     = r_busy_count;

    always_comb begin
        w_ren_hit = '0;
        w_com_hit = '0;
        w_com_clr = '0;
        for (int i = 1; i < 32; i++) begin
            w_ren_hit[i] = i_rename_en && !i_flush && (i_rename_addr == 5'(i));
            w_com_hit[i] = i_commit_en && (i_commit_addr == 5'(i));
            w_com_clr[i] = w_com_hit[i] && r_busy[i] && (r_tag[i] == i_commit_rsid);
        end
    end

    always_comb begin
        w_data_d = r_data;
        w_tag_d  = r_tag;
        w_busy_d = r_busy;
        for (int i = 1; i < 32; i++) begin
            if (w_com_hit[i]) begin
                w_data_d[i] = i_commit_data;
            end
            if (w_com_clr[i]) begin
                w_busy_d[i] = 1'b0;
            end
            // Rename after commit so a same-register rename keeps busy and wins the tag.
            if (w_ren_hit[i]) begin
                w_busy_d[i] = 1'b1;
                w_tag_d[i]  = i_rename_rsid;
            end
        end
        if (i_flush) begin
            w_busy_d = '0;
        end
    end

    always_comb begin
        w_inc = |(w_ren_hit & ~r_busy);
        w_dec = |(w_com_clr & ~w_ren_hit);
        if (i_flush) begin
            w_busy_count_d = '0;
        end else begin
            w_busy_count_d = r_busy_count + 5'(w_inc) - 5'(w_dec);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 1; i < 32; i++) begin
                r_data[i] <= '0;
                r_tag[i]  <= '0;
            end
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            r_data       <= w_data_d;
            r_tag        <= w_tag_d;
            r_busy       <= w_busy_d;
            r_busy_count <= w_busy_count_d;
        end
    end

endmodule

// File: tb/tb_rename_regfile.sv
// Directed bench for rename_regfile: rename, commit, flush, bypass and async reset.
module tb_rename_regfile;

    logic        clk;
    logic        rst_n;
    logic        rd_en_1, rd_en_2;
    logic [4:0]  rd_addr_1, rd_addr_2;
    logic        rd_is_rsid_1, rd_is_rsid_2;
    logic [31:0] rd_data_1, rd_data_2;
    logic        ren_en;
    logic [4:0]  ren_addr;
    logic [3:0]  ren_rsid;
    logic        com_en;
    logic [4:0]  com_addr;
    logic [3:0]  com_rsid;
    logic [31:0] com_data;
    logic        flush;
    logic [4:0]  busy_count;

    int n_total = 0;
    int n_pass  = 0;

    rename_regfile #(.RSID_WIDTH(4)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_read_en_1      (rd_en_1),
        .i_read_addr_1    (rd_addr_1),
        .o_read_is_rsid_1 (rd_is_rsid_1),
        .o_read_data_1    (rd_data_1),
        .i_read_en_2      (rd_en_2),
        .i_read_addr_2    (rd_addr_2),
        .o_read_is_rsid_2 (rd_is_rsid_2),
        .o_read_data_2    (rd_data_2),
        .i_rename_en      (ren_en),
        .i_rename_addr    (ren_addr),
        .i_rename_rsid    (ren_rsid),
        .i_commit_en      (com_en),
        .i_commit_addr    (com_addr),
        .i_commit_rsid    (com_rsid),
        .i_commit_data    (com_data),
        .i_flush          (flush),
        .o_busy_count     (busy_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk1(input string tag, input logic [4:0] a, input logic isr,
                        input logic [31:0] d);
        rd_en_1   = 1'b1;
        rd_addr_1 = a;
        #1;
        check(tag, {rd_is_rsid_1, rd_data_1}, {isr, d});
    endtask

    task automatic chk2(input string tag, input logic [4:0] a, input logic isr,
                        input logic [31:0] d);
        rd_en_2   = 1'b1;
        rd_addr_2 = a;
        #1;
        check(tag, {rd_is_rsid_2, rd_data_2}, {isr, d});
    endtask

    task automatic chk_cnt(input string tag, input logic [4:0] c);
        check(tag, {28'd0, busy_count}, {28'd0, c});
    endtask

    task automatic idle();
        ren_en = 1'b0; ren_addr = '0; ren_rsid = '0;
        com_en = 1'b0; com_addr = '0; com_rsid = '0; com_data = '0;
        flush  = 1'b0;
    endtask

    // Apply current inputs at the next edge, then return well away from it.
    task automatic tick();
        @(posedge clk);
        #2;
        idle();
    endtask

    task automatic rename(input logic [4:0] a, input logic [3:0] t);
        ren_en = 1'b1; ren_addr = a; ren_rsid = t;
    endtask

    task automatic commit(input logic [4:0] a, input logic [3:0] t, input logic [31:0] d);
        com_en = 1'b1; com_addr = a; com_rsid = t; com_data = d;
    endtask

    initial begin
        rst_n = 1'b0;
        rd_en_1 = 1'b0; rd_addr_1 = '0;
        rd_en_2 = 1'b0; rd_addr_2 = '0;
        idle();
        #12;
        chk1("reset_r5", 5'd5, 1'b0, 32'h0);
        chk2("reset_r0", 5'd0, 1'b0, 32'h0);
        chk_cnt("reset_cnt", 5'd0);
        rst_n = 1'b1;
        tick();

        rename(5'd3, 4'd7);
        chk1("self_read_pre_rename", 5'd3, 1'b0, 32'h0);
        tick();
        chk1("r3_rsid7", 5'd3, 1'b1, 32'h7);
        chk_cnt("cnt_after_rename", 5'd1);
        chk2("read_disabled_busy", 5'd3, 1'b1, 32'h7);
        rd_en_2 = 1'b0;
        #1;
        check("read_en0", {rd_is_rsid_2, rd_data_2}, 33'h0);

        rename(5'd3, 4'd9);
        tick();
        chk_cnt("cnt_rerename", 5'd1);
        commit(5'd3, 4'd7, 32'hDEADBEEF);
        tick();
        chk1("stale_commit_keeps_rsid9", 5'd3, 1'b1, 32'h9);
        chk_cnt("cnt_stale_commit", 5'd1);
        commit(5'd3, 4'd9, 32'h12345678);
        tick();
        chk1("commit_match_value", 5'd3, 1'b0, 32'h12345678);
        chk_cnt("cnt_commit_match", 5'd0);

        rename(5'd3, 4'd9);
        tick();
        commit(5'd3, 4'd9, 32'hCAFEF00D);
`ifdef RENAME_BYPASS_EN
        chk1("bypass_same_cycle", 5'd3, 1'b0, 32'hCAFEF00D);
`else
        chk1("no_bypass_same_cycle", 5'd3, 1'b1, 32'h9);
`endif
        tick();
        chk1("commit_visible_next", 5'd3, 1'b0, 32'hCAFEF00D);
        chk_cnt("cnt_after_cafe", 5'd0);

        rename(5'd1, 4'd1);
        tick();
        rename(5'd2, 4'd3);
        tick();
        rename(5'd4, 4'd4);
        tick();
        chk_cnt("cnt_three_busy", 5'd3);
        flush = 1'b1;
        rename(5'd5, 4'd2);
        commit(5'd2, 4'd5, 32'h55);
        tick();
        chk1("flush_r1", 5'd1, 1'b0, 32'h0);
        chk2("flush_r2_data", 5'd2, 1'b0, 32'h55);
        chk1("flush_r4", 5'd4, 1'b0, 32'h0);
        chk2("flush_r5_dropped", 5'd5, 1'b0, 32'h0);
        chk_cnt("cnt_flush", 5'd0);

        rename(5'd6, 4'd10);
        tick();
        rename(5'd6, 4'd11);
        commit(5'd6, 4'd10, 32'hAA);
        tick();
        chk1("rename_wins_tag", 5'd6, 1'b1, 32'hB);
        chk_cnt("cnt_same_reg", 5'd1);
        commit(5'd6, 4'd11, 32'hBB);
        rename(5'd7, 4'd12);
        tick();
        chk1("r6_committed", 5'd6, 1'b0, 32'hBB);
        chk2("r7_busy", 5'd7, 1'b1, 32'hC);
        chk_cnt("cnt_plus_minus", 5'd1);

        rename(5'd0, 4'd5);
        commit(5'd0, 4'd5, 32'h77);
        tick();
        chk1("r0_ignored", 5'd0, 1'b0, 32'h0);
        chk_cnt("cnt_r0_ignored", 5'd1);

        commit(5'd7, 4'd12, 32'h99);
        rst_n = 1'b0;
        chk2("reset_async_r7", 5'd7, 1'b0, 32'h0);
        chk1("reset_async_r6", 5'd6, 1'b0, 32'h0);
        chk_cnt("reset_async_cnt", 5'd0);
        idle();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        rename(5'd8, 4'd3);
        tick();
        chk1("first_edge_after_reset", 5'd8, 1'b1, 32'h3);
        chk_cnt("cnt_after_reset_release", 5'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rename_regfile.md
# rename_regfile

Architectural register file with per-register rename tags. It is the responder behind the ID stage's two register read ports and its destination-register output. For each source operand it returns either committed data or the reservation-station/ROB id (rsid) that will produce the value. ID-issued destinations are renamed to a new rsid. ROB commits write values back, and a flush drops all outstanding renames.

## Interface
- `RSID_WIDTH`, default 4: width of an rsid (16 in-flight producers).
- `clk  in  1`: clock, rising edge.
- `rst  in  1`: reset, asynchronous, active-low.
- `read_en_1`, `read_en_2  in  1`: read port enables (from ID).
- `read_addr_1`, `read_addr_2  in  5`: source register numbers.
- `read_is_rsid_1`, `read_is_rsid_2  out  1`: 1 means `read_data_x` carries an rsid, not a value.
- `read_data_1`, `read_data_2  out  32`: committed value, or the rsid zero-extended to 32 bits.
- `rename_en  in  1`: ID instruction writes a register.
- `rename_addr  in  5`: destination register.
- `rename_rsid  in  RSID_WIDTH`: rsid allocated to that instruction (from ROB).
- `commit_en  in  1`: ROB retires a register-writing instruction.
- `commit_addr  in  5`: retired destination.
- `commit_rsid  in  RSID_WIDTH`: rsid of the retiring instruction.
- `commit_data  in  32`: retired result.
- `flush  in  1`: ROB flush (exception / mispredict).
- `busy_count  out  5`: registered count of registers currently holding a rename tag.

## Operation
- State per register r1..r31: `data[31:0]`, `busy`, `tag[RSID_WIDTH-1:0]`.
- r0 has no state:
  - Reads of r0 return data 0 with is_rsid 0.
  - Renames and commits to r0 are ignored.
- Read ports are combinational:
  - `read_en_x`=0: outputs data 0, is_rsid 0.
  - Register not busy: data = `data[r]`, is_rsid 0.
  - Register busy: data = {0, `tag[r]`}, is_rsid 1.
- Reads never see a same-cycle rename. An instruction reading its own destination (e.g. `addu $1,$1,$2`) gets the pre-rename mapping.
- Rename, at the clock edge, when `rename_en` and `flush`=0: `busy[a]`←1, `tag[a]`←`rename_rsid`. This overwrites any older tag.
- Commit, at the clock edge, when `commit_en`:
  - `data[a]`←`commit_data`, always.
  - If `busy[a]` and `tag[a]`==`commit_rsid`, `busy[a]`←0. A mismatched tag leaves busy unchanged, because a younger rename is still pending.
- Same register renamed and committed in one cycle: data takes `commit_data`, busy stays 1, tag takes `rename_rsid`. Rename wins the tag.
- Flush, at the clock edge: all `busy`←0.
  - A commit in the same cycle still writes its data.
  - A rename in the same cycle is discarded.
- `busy_count` is the number of busy bits after each edge:
  - +1 for a rename to a non-busy register.
  - −1 for a tag-matching commit with no same-register rename.
  - 0 on flush.
  - The value must always equal the popcount of the busy bits.

## Timing
- Read latency 0: combinational from addr/en and current state.
- Rename and commit take effect at the next rising edge and are visible to reads in the following cycle. The exception is the commit bypass described under Configuration.
- Reset, asynchronous on `rst`=0, clears all data, busy, tag and `busy_count`. While `rst`=0, read outputs are 0 / is_rsid 0 regardless of inputs.
- Reset released mid-stream: the first edge after deassertion processes inputs normally.
- At most one rename and one commit per cycle. No backpressure: every asserted request is accepted.

## Configuration
- `RENAME_BYPASS_EN` defined: the commit is bypassed to the read ports in the same cycle.
  - Condition: a read of a busy register whose `tag` equals `commit_rsid`, with `commit_en`=1 and `commit_addr` equal to the read address.
  - Result: the read returns `commit_data` with is_rsid 0.
  - Flush does not suppress the bypass.
- `RENAME_BYPASS_EN` undefined: reads reflect registered state only. The commit is visible one cycle later.

## Test plan
- Reset, then read r5 and r0 -> data 0, is_rsid 0, `busy_count`=0.
- Rename r3→rsid 7, then read r3 next cycle -> is_rsid 1, data 0x00000007, `busy_count`=1.
- Rename r3→7, then r3→9, then commit r3/rsid 7/0xDEADBEEF -> read r3 gives rsid 9, busy still 1. Then commit r3/rsid 9/0x12345678 -> read gives 0x12345678, is_rsid 0, `busy_count`=0.
- r3 busy with tag 9, commit r3/rsid 9/0xCAFEF00D while reading r3 in the same cycle:
  - `RENAME_BYPASS_EN` defined -> 0xCAFEF00D, is_rsid 0, in that cycle.
  - Undefined -> rsid 9 that cycle, value the next cycle.
- Rename r1, r2 and r4, then flush with a simultaneous rename r5→2 and commit r2/rsid x/0x55 -> all reads non-rsid, r2=0x55, r5 not busy, `busy_count`=0.
- Rename and commit r0, then assert `rst` low mid-sequence -> r0 reads 0, and all state is cleared asynchronously before the next edge.
